dmem_store_buffer: RTL and testbench

//  Data-side memory stage directly downstream of the mips core.
//  - Consumes memwrite/aluout/writedata and returns readdata.
//  - Posts stores into a DEPTH-entry FIFO and drains them to a slow external bus over a req/ready handshake.
//  - Forwards load data from pending stores; stalls the core on a load miss or when the buffer is full.

---
 rtl/dmem_store_buffer.sv | 165 ++++++++++++++++
 tb/tb_dmem_store_buffer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_store_buffer.sv
// Data-side store buffer between the mips core and a slow req/ready bus.
// Optional macro SB_FORWARD_EN: load forwarding plus load-before-drain priority; without it loads wait for a full drain.
module dmem_store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          memwrite,
    input  logic          memread,
    input  logic [AW-1:0] aluout,
    input  logic [DW-1:0] writedata,
    output logic [DW-1:0] readdata,
    output logic          stall,
    output logic          bus_req,
    output logic          bus_we,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    input  logic          bus_ready,
    input  logic [DW-1:0] bus_rdata
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, ST_REQ, LD_REQ, LD_DONE} state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-3:0] ent_addr_q [DEPTH];
    logic [DW-1:0] ent_data_q [DEPTH];
    logic [DW-1:0] ld_data_q;
    logic          bus_req_q, bus_req_d, bus_we_q, bus_we_d;
    logic [AW-1:0] bus_addr_q, bus_addr_d;
    logic [DW-1:0] bus_wdata_q, bus_wdata_d;
    logic          full, empty, enq, deq, hit, ld_miss;
    logic [DW-1:0] fwd_data;
    logic          unused_low_bits;

    assign unused_low_bits = ^aluout[1:0];
    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign enq     = memwrite && !full;
    assign deq     = (state_q == ST_REQ) && bus_ready;
    assign head_d  = deq ? head_q + PW'(1) : head_q;
    assign tail_d  = enq ? tail_q + PW'(1) : tail_q;
    assign count_d = count_q + CW'(enq) - CW'(deq);

`ifdef SB_FORWARD_EN
    // Scan oldest to youngest so the youngest matching entry wins.
    always_comb begin
        hit      = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < count_q) && (ent_addr_q[head_q + PW'(i)] == aluout[AW-1:2])) begin
                hit      = 1'b1;
                fwd_data = ent_data_q[head_q + PW'(i)];
            end
        end
    end
    assign ld_miss = memread && !hit;
`else
    assign hit      = 1'b0;
    assign fwd_data = '0;
    assign ld_miss  = memread;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            ld_data_q   <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            if (state_q == LD_REQ && bus_ready) ld_data_q <= bus_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            ent_addr_q[tail_q] <= aluout[AW-1:2];
            ent_data_q[tail_q] <= writedata;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
`ifdef SB_FORWARD_EN
                if (ld_miss)     state_d = LD_REQ;
                else if (!empty) state_d = ST_REQ;
`else
                if (!empty)       state_d = ST_REQ;
                else if (ld_miss) state_d = LD_REQ;
`endif
            end
            ST_REQ: if (bus_ready) begin
`ifdef SB_FORWARD_EN
                if (ld_miss)                  state_d = LD_REQ;
                else if (count_q > CW'(1))    state_d = ST_REQ;
                else                          state_d = IDLE;
`else
                if (count_q > CW'(1))         state_d = ST_REQ;
                else if (ld_miss)             state_d = LD_REQ;
                else                          state_d = IDLE;
`endif
            end
            LD_REQ:  if (bus_ready) state_d = LD_DONE;
            LD_DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus outputs are computed from the next state and registered.
    always_comb begin
        stall       = 1'b0;
        readdata    = '0;
        bus_req_d   = 1'b0;
        bus_we_d    = 1'b0;
        bus_addr_d  = '0;
        bus_wdata_d = '0;
        if (reset) begin
            if (memwrite && full) stall = 1'b1;
            else if (memread) begin
                if (state_q == LD_DONE) readdata = ld_data_q;
                else if (hit)           readdata = fwd_data;
                else                    stall    = 1'b1;
            end
        end
        case (state_d)
            ST_REQ: begin
                bus_req_d   = 1'b1;
                bus_we_d    = 1'b1;
                bus_addr_d  = {ent_addr_q[head_d], 2'b00};
                bus_wdata_d = ent_data_q[head_d];
            end
            LD_REQ: begin
                bus_req_d  = 1'b1;
                bus_addr_d = {aluout[AW-1:2], 2'b00};
            end
            default: ;
        endcase
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
endmodule

// File: tb/tb_dmem_store_buffer.sv
// Bench for dmem_store_buffer: directed vector table, hand sequences, and random traffic vs a queue model.
module tb_dmem_store_buffer;
    localparam int DEPTH = 4;
`ifdef SB_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk, reset, memwrite, memread, stall, bus_req, bus_we, bus_ready;
    logic [31:0] aluout, writedata, readdata, bus_addr, bus_wdata, bus_rdata;
    int          n_checks = 0;
    int          n_fail = 0;

    dmem_store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
        .clk(clk), .reset(reset), .memwrite(memwrite), .memread(memread),
        .aluout(aluout), .writedata(writedata), .readdata(readdata), .stall(stall),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_ready(bus_ready), .bus_rdata(bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        mw, mr;
        logic [31:0] addr, wd;
        logic        rdy;
        logic [31:0] rdat;
        logic        e_stall;
        logic [31:0] e_rd;
        logic        e_req, e_we;
        logic [31:0] e_addr;
    } vec_t;

    typedef struct {
        logic [29:0] w;
        logic [31:0] d;
    } ent_t;

    vec_t        vecs [15];
    ent_t        q [$];
    logic [31:0] arch [logic [29:0]];
    logic [31:0] bmem [logic [29:0]];

    function automatic vec_t mk(logic mw, logic mr, logic [31:0] a, logic [31:0] wd, logic rdy,
                                logic [31:0] rdat, logic es, logic [31:0] erd, logic ereq,
                                logic ewe, logic [31:0] eaddr);
        vec_t v;
        v.mw = mw; v.mr = mr; v.addr = a; v.wd = wd; v.rdy = rdy; v.rdat = rdat;
        v.e_stall = es; v.e_rd = erd; v.e_req = ereq; v.e_we = ewe; v.e_addr = eaddr;
        return v;
    endfunction

    function automatic logic [31:0] init_val(logic [29:0] w);
        return {w, 2'b00} ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [31:0] arch_rd(logic [29:0] w);
        if (arch.exists(w)) return arch[w];
        return init_val(w);
    endfunction

    function automatic logic [31:0] bmem_rd(logic [29:0] w);
        if (bmem.exists(w)) return bmem[w];
        return init_val(w);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: expected event did not occur", name);
    endtask

    task automatic cyc(input logic mw, input logic mr, input logic [31:0] a, input logic [31:0] wd,
                       input logic rdy, input logic [31:0] rd);
        @(posedge clk); #1;
        memwrite = mw; memread = mr; aluout = a; writedata = wd; bus_ready = rdy; bus_rdata = rd;
        @(negedge clk);
    endtask

    task automatic do_reset();
        memwrite = 1'b0; memread = 1'b0; aluout = '0; writedata = '0; bus_ready = 1'b0; bus_rdata = '0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic        busy, fresh, hit, prev_wait, p_we, done;
        logic [31:0] p_addr, p_wd;
        logic [29:0] w;
        int unsigned r;
        int          stall_run;
        logic        lg_we [$];
        logic [31:0] lg_addr [$];
        logic [31:0] lg_wd [$];

        // Miss latency with idle bus, then fill/stall/drain of the FIFO.
        vecs[0]  = mk(1'b0, 1'b1, 32'h80, 32'h0,   1'b1, 32'h1234, 1'b1, 32'h0,    1'b0, 1'b0, 32'h0);
        vecs[1]  = mk(1'b0, 1'b1, 32'h80, 32'h0,   1'b1, 32'h1234, 1'b1, 32'h0,    1'b1, 1'b0, 32'h80);
        vecs[2]  = mk(1'b0, 1'b1, 32'h80, 32'h0,   1'b1, 32'h1234, 1'b0, 32'h1234, 1'b0, 1'b0, 32'h0);
        vecs[3]  = mk(1'b0, 1'b0, 32'h0,  32'h0,   1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 1'b0, 32'h0);
        vecs[4]  = mk(1'b1, 1'b0, 32'h10, 32'h100, 1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 1'b0, 32'h0);
        vecs[5]  = mk(1'b1, 1'b0, 32'h14, 32'h101, 1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 1'b0, 32'h0);
        vecs[6]  = mk(1'b1, 1'b0, 32'h18, 32'h102, 1'b0, 32'h0,    1'b0, 32'h0,    1'b1, 1'b1, 32'h10);
        vecs[7]  = mk(1'b1, 1'b0, 32'h1C, 32'h103, 1'b0, 32'h0,    1'b0, 32'h0,    1'b1, 1'b1, 32'h10);
        vecs[8]  = mk(1'b1, 1'b0, 32'h20, 32'h104, 1'b0, 32'h0,    1'b1, 32'h0,    1'b1, 1'b1, 32'h10);
        vecs[9]  = mk(1'b1, 1'b0, 32'h20, 32'h104, 1'b1, 32'h0,    1'b1, 32'h0,    1'b1, 1'b1, 32'h10);
        vecs[10] = mk(1'b1, 1'b0, 32'h20, 32'h104, 1'b1, 32'h0,    1'b0, 32'h0,    1'b1, 1'b1, 32'h14);
        vecs[11] = mk(1'b0, 1'b0, 32'h0,  32'h0,   1'b1, 32'h0,    1'b0, 32'h0,    1'b1, 1'b1, 32'h18);
        vecs[12] = mk(1'b0, 1'b0, 32'h0,  32'h0,   1'b1, 32'h0,    1'b0, 32'h0,    1'b1, 1'b1, 32'h1C);
        vecs[13] = mk(1'b0, 1'b0, 32'h0,  32'h0,   1'b1, 32'h0,    1'b0, 32'h0,    1'b1, 1'b1, 32'h20);
        vecs[14] = mk(1'b0, 1'b0, 32'h0,  32'h0,   1'b1, 32'h0,    1'b0, 32'h0,    1'b0, 1'b0, 32'h0);

        // Reset state
        memwrite = 1'b0; memread = 1'b0; aluout = '0; writedata = '0; bus_ready = 1'b0; bus_rdata = '0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_bus_req", bus_req, 1'b0);
        chk("rst_bus_we", bus_we, 1'b0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_bus_wdata", bus_wdata, 32'h0);
        chk("rst_stall", stall, 1'b0);
        chk("rst_readdata", readdata, 32'h0);
        reset = 1'b1;

        for (int i = 0; i < 15; i++) begin
            cyc(vecs[i].mw, vecs[i].mr, vecs[i].addr, vecs[i].wd, vecs[i].rdy, vecs[i].rdat);
            chk($sformatf("vec%0d_stall", i), stall, vecs[i].e_stall);
            chk($sformatf("vec%0d_readdata", i), readdata, vecs[i].e_rd);
            chk($sformatf("vec%0d_bus_req", i), bus_req, vecs[i].e_req);
            if (vecs[i].e_req) begin
                chk($sformatf("vec%0d_bus_we", i), bus_we, vecs[i].e_we);
                chk($sformatf("vec%0d_bus_addr", i), bus_addr, vecs[i].e_addr);
            end
        end

        // Async reset while a store request is pending and the buffer is full
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 32'h10 + 4 * i, 32'h100 + i, 1'b0, 32'h0);
        chk("ar_pre_stall", stall, 1'b1);
        chk("ar_pre_req", bus_req, 1'b1);
        #1 reset = 1'b0;
        #1;
        chk("ar_bus_req", bus_req, 1'b0);
        chk("ar_stall", stall, 1'b0);
        chk("ar_readdata", readdata, 32'h0);

        // Load issued while a store request waits: store first, then the load
        do_reset();
        cyc(1'b1, 1'b0, 32'h100, 32'h55, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 32'h200, 32'h0, 1'b0, 32'h0);
        chk("s5_req", bus_req, 1'b1);
        chk("s5_we", bus_we, 1'b1);
        chk("s5_stall", stall, 1'b1);
        repeat (2) cyc(1'b0, 1'b1, 32'h200, 32'h0, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 32'h200, 32'h0, 1'b1, 32'h0);
        chk("s5_st_we", bus_we, 1'b1);
        chk("s5_st_addr", bus_addr, 32'h100);
        cyc(1'b0, 1'b1, 32'h200, 32'h0, 1'b1, 32'h777);
        chk("s5_ld_req", bus_req, 1'b1);
        chk("s5_ld_we", bus_we, 1'b0);
        chk("s5_ld_addr", bus_addr, 32'h200);
        chk("s5_ld_stall", stall, 1'b1);
        cyc(1'b0, 1'b1, 32'h200, 32'h0, 1'b1, 32'h0);
        chk("s5_done_stall", stall, 1'b0);
        chk("s5_done_data", readdata, 32'h777);

        // Two stores to one word then a load of it: forwarding or strict drain order
        do_reset();
        cyc(1'b1, 1'b0, 32'h40, 32'hAAAA, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 32'h40, 32'hBBBB, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 32'h42, 32'h0, 1'b0, 32'h4444);
`ifdef SB_FORWARD_EN
        chk("fw_stall", stall, 1'b0);
        chk("fw_data", readdata, 32'hBBBB);
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
            if (bus_req && bus_ready) begin
                lg_we.push_back(bus_we); lg_addr.push_back(bus_addr); lg_wd.push_back(bus_wdata);
            end
            done = (lg_we.size() == 2);
        end
        if (!done) fail_now("fw_drain");
        else begin
            chk("fw_d0_addr", lg_addr[0], 32'h40);
            chk("fw_d0_data", lg_wd[0], 32'hAAAA);
            chk("fw_d1_addr", lg_addr[1], 32'h40);
            chk("fw_d1_data", lg_wd[1], 32'hBBBB);
        end
`else
        chk("nf_stall", stall, 1'b1);
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            cyc(1'b0, 1'b1, 32'h42, 32'h0, 1'b1, 32'h4444);
            if (bus_req && bus_ready) begin
                lg_we.push_back(bus_we); lg_addr.push_back(bus_addr); lg_wd.push_back(bus_wdata);
            end
            done = !stall;
        end
        if (!done || lg_we.size() != 3) fail_now("nf_order");
        else begin
            chk("nf_data", readdata, 32'h4444);
            chk("nf_h0", {lg_we[0], lg_addr[0][7:0], lg_wd[0][15:0]}, {1'b1, 8'h40, 16'hAAAA});
            chk("nf_h1", {lg_we[1], lg_addr[1][7:0], lg_wd[1][15:0]}, {1'b1, 8'h40, 16'hBBBB});
            chk("nf_h2_we", lg_we[2], 1'b0);
            chk("nf_h2_addr", lg_addr[2], 32'h40);
        end
`endif

        // Random traffic against the architectural-memory model
        do_reset();
        q.delete(); arch.delete(); bmem.delete();
        busy = 1'b0; prev_wait = 1'b0; stall_run = 0;
        p_we = 1'b0; p_addr = '0; p_wd = '0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            fresh = !busy;
            if (!busy) begin
                r = $urandom_range(0, 9);
                memwrite = 1'b0; memread = 1'b0;
                aluout = 32'h40 + 4 * $urandom_range(0, 7) + $urandom_range(0, 3);
                if (r < 4) begin
                    memwrite = 1'b1; writedata = $urandom;
                end else if (r < 7) begin
                    memread = 1'b1;
                    if ($urandom_range(0, 3) == 0) aluout = aluout + 32'h100;
                end
            end
            bus_ready = ($urandom_range(0, 2) != 0);
            bus_rdata = bmem_rd(bus_addr[31:2]);
            @(negedge clk);

            w = aluout[31:2];
            hit = 1'b0;
            foreach (q[i]) if (q[i].w == w) hit = 1'b1;
            if (prev_wait) begin
                chk("hold_req", bus_req, 1'b1);
                chk("hold_we", bus_we, p_we);
                chk("hold_addr", bus_addr, p_addr);
                chk("hold_wdata", bus_wdata, p_wd);
            end
            if (memwrite) chk("st_stall", stall, q.size() == DEPTH);
            if (memread) begin
                if (fresh) chk("ld_first_stall", stall, !(FWD && hit));
                if (!stall) chk("ld_data", readdata, arch_rd(w));
            end
            if (!(memread && !stall)) chk("rd_zero", readdata, 32'h0);
            if (!memwrite && !memread) chk("idle_stall", stall, 1'b0);
            if (bus_req && bus_ready) begin
                if (bus_we) begin
                    if (q.size() == 0) fail_now("st_unexpected");
                    else begin
                        chk("st_addr", bus_addr, {q[0].w, 2'b00});
                        chk("st_data", bus_wdata, q[0].d);
                        bmem[q[0].w] = q[0].d;
                        void'(q.pop_front());
                    end
                end else begin
                    chk("ld_req_valid", memread, 1'b1);
                    chk("ld_addr", bus_addr, {w, 2'b00});
`ifdef SB_FORWARD_EN
                    chk("ld_bypass", hit, 1'b0);
`else
                    chk("ld_order", q.size(), 32'h0);
`endif
                end
            end
            if (memwrite && !stall) begin
                q.push_back('{w, writedata});
                arch[w] = writedata;
            end
            busy = (memwrite || memread) && stall;
            prev_wait = bus_req && !bus_ready;
            p_we = bus_we; p_addr = bus_addr; p_wd = bus_wdata;
            stall_run = stall ? stall_run + 1 : 0;
            if (stall_run > 100) begin
                fail_now("stall_watchdog");
                break;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
